// File: rtl/spn_iter_core.sv
// Iterative SPN block cipher: whiten on accept, then one S/P/key round per cycle.
// Latency NR cycles from accept to out_valid; result held until out_ready, no new accept meanwhile.
module spn_iter_core #(
    parameter int DW = 16,
    parameter int KW = 32,
    parameter int NR = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    opcode,
    input  logic [DW-1:0] data_i,
    input  logic [KW-1:0] key_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] data_o,
    output logic [1:0]    valid,
    output logic          busy
);

    localparam int CW = $clog2(NR + 1);
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] key_q;
    logic [1:0]    op_q;
    logic [DW-1:0] s_q;
    logic [CW-1:0] rnd_q;
    logic          start;
    logic          last_round;
    logic [DW-1:0] enc_step, dec_step, round_out;

    // Rotation amounts are constants per round index, so the rotate is a mux of fixed wirings.
    function automatic logic [DW-1:0] round_key(input logic [KW-1:0] k, input logic [CW-1:0] r);
        logic [DW-1:0] rk;
        logic [KW-1:0] rot;
        rk  = k[DW-1:0];
        rot = k;
        for (int i = 1; i <= NR; i++) begin
            if (r == CW'(i)) begin
                rot = (k >> ((4 * i) % KW)) | (k << ((KW - (4 * i) % KW) % KW));
                rk  = rot[DW-1:0];
            end
        end
        return rk;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hD;  4'h3: y = 4'h1;
            4'h4: y = 4'h2;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h8;
            4'h8: y = 4'h3;  4'h9: y = 4'hA;  4'hA: y = 4'h6;  4'hB: y = 4'hC;
            4'hC: y = 4'h5;  4'hD: y = 4'h9;  4'hE: y = 4'h0;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h3;  4'h2: y = 4'h4;  4'h3: y = 4'h8;
            4'h4: y = 4'h1;  4'h5: y = 4'hC;  4'h6: y = 4'hA;  4'h7: y = 4'hF;
            4'h8: y = 4'h7;  4'h9: y = 4'hD;  4'hA: y = 4'h9;  4'hB: y = 4'h6;
            4'hC: y = 4'hB;  4'hD: y = 4'h2;  4'hE: y = 4'h0;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [DW-1:0] sub_layer(input logic [DW-1:0] x, input logic inv);
        logic [DW-1:0] y;
        y = '0;
        for (int n = 0; n < DW / 4; n++) begin
            y[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Multiplying by 4 is a bijection mod DW-1 because DW-1 is odd; the MSB stays put.
    function automatic logic [DW-1:0] perm(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = '0;
        for (int i = 0; i < DW - 1; i++) begin
            y[(4 * i) % (DW - 1)] = x[i];
        end
        y[DW-1] = x[DW-1];
        return y;
    endfunction

    function automatic logic [DW-1:0] perm_inv(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = '0;
        for (int i = 0; i < DW - 1; i++) begin
            y[i] = x[(4 * i) % (DW - 1)];
        end
        y[DW-1] = x[DW-1];
        return y;
    endfunction

    always_comb begin
        enc_step = sub_layer(s_q, 1'b0);
        if (rnd_q != CW'(NR)) begin
            enc_step = perm(enc_step);
        end
        enc_step = enc_step ^ round_key(key_q, rnd_q);

        dec_step = (rnd_q != CW'(NR)) ? perm_inv(s_q) : s_q;
        dec_step = sub_layer(dec_step, 1'b1) ^ round_key(key_q, rnd_q - CW'(1));

        round_out  = (op_q == OP_ENC) ? enc_step : dec_step;
        last_round = (op_q == OP_ENC) ? (rnd_q == CW'(NR)) : (rnd_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid && (opcode == OP_ENC || opcode == OP_DEC)) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_round) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid = out_valid ? op_q : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q  <= '0;
            op_q   <= 2'b00;
            s_q    <= '0;
            rnd_q  <= '0;
            data_o <= '0;
        end else if (start) begin
            key_q <= key_i;
            op_q  <= opcode;
            if (opcode == OP_ENC) begin
                s_q   <= data_i ^ round_key(key_i, CW'(0));
                rnd_q <= CW'(1);
            end else begin
                s_q   <= data_i ^ round_key(key_i, CW'(NR));
                rnd_q <= CW'(NR);
            end
        end else if (state_q == RUN) begin
            s_q <= round_out;
            if (last_round) begin
                data_o <= round_out;
            end else if (op_q == OP_ENC) begin
                rnd_q <= rnd_q + CW'(1);
            end else begin
                rnd_q <= rnd_q - CW'(1);
            end
        end
    end

endmodule

// File: doc/spn_iter_core.md
# spn_iter_core

Parametrised iterative SPN cipher engine, the next generation of the fixed 16-bit/32-bit `spn_if` datapath. It adds generic block/key width and round count, one-round-per-cycle iteration, and valid/ready handshakes on both sides so it can sit between a host front-end and a result FIFO. Opcode semantics are unchanged: encrypt, decrypt, nop, with the result tagged by its opcode.

## Interface
- `DW`, 16: block width; multiple of 4, 16..64.
- `KW`, 32: key width; multiple of 4, ≥ DW.
- `NR`, 4: number of rounds, 1..15.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  core can accept a request this cycle.
- `opcode`  in  2  00 = nop, 01 = encrypt, 10 = decrypt, 11 = reserved.
- `data_i`  in  DW  plaintext or ciphertext.
- `key_i`  in  KW  secret key; sampled with the request.
- `out_valid`  out  1  result held on `data_o`.
- `out_ready`  in  1  consumer takes the result.
- `data_o`  out  DW  result.
- `valid`  out  2  opcode of the held result (01/10); 00 when `out_valid`=0.
- `busy`  out  1  round iteration in progress.

## Operation
- Handshakes: accept on `in_valid & in_ready`; emit on `out_valid & out_ready`.
- Opcodes 00 and 11 are accepted and dropped. They produce no output, change no state, and leave `in_ready` high.
- Opcodes 01 and 10 latch `key_i`, the opcode, and the whitened state.
- Round keys: `K_r` = low DW bits of (latched key rotated right by 4·r mod KW), for r = 0..NR.
- S: nibble-wise 4-bit S-box 0..F → E,4,D,1,2,F,B,8,3,A,6,C,5,9,0,7. Sinv is its exact inverse.
- P: bit i moves to (4·i) mod (DW−1) for i < DW−1. Bit DW−1 is fixed. Pinv is the inverse.
- Encrypt:
  - On accept: s = data_i ^ K_0.
  - Round r = 1..NR: s = S(s); then if r < NR, s = P(s); then s = s ^ K_r.
- Decrypt:
  - On accept: s = data_i ^ K_NR.
  - Round r = NR..1: if r < NR, s = Pinv(s); then s = Sinv(s); then s = s ^ K_(r−1).
- FSM:
  - IDLE: `in_ready`=1. A valid 01/10 accept goes to RUN with round counter initialised.
  - RUN: one round per cycle, `busy`=1. After the last round, `data_o` is loaded and the FSM goes to DONE.
  - DONE: `out_valid`=1. On `out_ready` the FSM returns to IDLE.
- Round counter is ceil(log2(NR+1)) bits wide. It counts up for encrypt and down for decrypt, with no wrap.
- `data_o` and `valid` hold stable through DONE regardless of input activity.
- Request inputs are ignored outside IDLE; `in_ready`=0 in RUN and DONE.

## Timing
- Reset (synchronous, `rst_n`=0 at a rising edge): FSM → IDLE.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `busy`=0, `valid`=00, `data_o`=0.
  - Reset during RUN or DONE abandons the operation; no result is ever emitted.
- Latency: accept at edge 0; rounds complete at edges 1..NR. `out_valid` rises after edge NR, so the result is presented NR cycles after accept.
- `out_ready` already high when DONE is entered: the result is consumed at edge NR+1. IDLE (`in_ready`=1) returns after edge NR+1.
- Throughput: one operation per NR+2 cycles.
- No combinational path from `in_valid` or `out_ready` to any output. All outputs are registered or decoded from FSM state only.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles, then release.
  - Required: `in_ready`=1, `out_valid`=0, `busy`=0, `valid`=00, `data_o`=0000.
- Known-answer, NR=1, DW=16, KW=32, key 0000_0000, encrypt 0000:
  - Required: `data_o`=EEEE, `valid`=01, `out_valid` exactly 1 cycle after accept.
- Known-answer, NR=1, key 0000_FFFF, encrypt 0000:
  - K_0=FFFF, K_1=0FFF.
  - Required: `data_o`=7888. Decrypting 7888 with the same key returns 0000 with `valid`=10.
- Round trip, NR=4, DW=16/KW=32 and DW=32/KW=64, 1000 random data/key pairs:
  - Required: decrypt(encrypt(x)) = x.
  - Required: `busy` high for exactly 4 cycles per operation; `out_valid` 4 cycles after accept.
- Backpressure and ignores:
  - Hold `out_ready`=0 for 10 cycles in DONE → `data_o`/`valid` stable, `in_ready`=0.
  - Drive new requests during RUN/DONE → ignored.
  - Opcodes 00/11 in IDLE → no output, `in_ready` stays 1.
- Reset mid-operation: assert `rst_n`=0 at round 2 of NR=4.
  - Required: no `out_valid` ever for that request; IDLE with `in_ready`=1 on the cycle after release.
